aska_seq: RTL and testbench
===========================

# aska_seq

Electrode-pattern sequencer sitting between `aska_spi` and `aska_npg` in `aska_dig`. Holds a small table of electrode-pair patterns (`ele1`/`ele2`) and drives one pattern into the pulse generator at a time. After a programmed number of stimulation pulses it rotates round-robin through the enabled slots. Pattern changes happen only while `pulse_active` is low, so the H-bridge selection never changes mid-pulse.

## Interface
- `NSLOT`, 4: number of pattern slots (power of 2, 2..8).
- `ELE_W`, 32: electrode vector width.
- `CNT_W`, 8: pulse-count width.
- `clk`  in  1  internal clock (20 kHz).
- `resetn`  in  1  asynchronous active-low reset.
- `enable`  in  1  sequencing enable (conf1 enable bit).
- `pulse_active`  in  1  from `aska_npg`; high during a biphasic pulse.
- `slot_mask`  in  NSLOT  slot enable bits.
- `pulses_per_slot`  in  CNT_W  pulses per slot before rotating; 0 is treated as 1.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  $clog2(NSLOT)  table write slot.
- `wr_ele1`, `wr_ele2`  in  ELE_W  pattern data to write.
- `ele1`, `ele2`  out  ELE_W  active pattern to `aska_npg`.
- `slot_idx`  out  $clog2(NSLOT)  index of the active slot.
- `slot_strobe`  out  1  one-cycle pulse on every pattern load.
- `fault`  out  1  sticky overlap fault (see Configuration).

## Operation
- Table: NSLOT × {ele1, ele2} registers, written on `wr_en`. A write to the active slot does not change `ele1`/`ele2` until that slot is next loaded.
- States:
  - IDLE: outputs zero. Leaves when `enable` is high, an eligible slot exists, and `pulse_active` is low. Next state is LOAD.
  - LOAD: one cycle. Copies the picked slot to `ele1`/`ele2`/`slot_idx`, pulses `slot_strobe`, clears the count. Next state is RUN.
  - RUN: counts pulses on the `pulse_active` falling edge (registered previous value). When count+1 ≥ max(`pulses_per_slot`,1), goes to SWITCH.
  - SWITCH: waits until `pulse_active` is low.
    - If `enable` is low or no slot is eligible: go to IDLE.
    - Otherwise: go to LOAD with the next eligible slot.
- Eligibility:
  - A slot is eligible when its `slot_mask` bit is 1, plus the overlap rule when compiled in.
  - Selection is round-robin: search starts at `slot_idx`+1 and wraps modulo NSLOT.
  - From IDLE the search starts at slot 0.
  - If only one slot is eligible, the same slot is reloaded (`slot_strobe` still pulses).
- `enable` falling in RUN:
  - Go to SWITCH immediately. Outputs are held until `pulse_active` is low, then state goes to IDLE.
  - Outputs are zeroed on entry to IDLE, never while `pulse_active` is high.
- `slot_mask` changes take effect at the next selection only.
- Count saturates and never wraps.

## Timing
- Reset values: `ele1`=`ele2`=0, `slot_idx`=0, `slot_strobe`=0, `fault`=0, table all 0, state IDLE, count 0.
- IDLE→LOAD decision at cycle t. Outputs are valid and `slot_strobe`=1 at t+1 (registered).
- Falling edge seen at cycle t (`pulse_active`=0, prev=1) increments the count at t+1.
- From the last counted falling edge to the new pattern: 2 cycles (SWITCH, LOAD) if `pulse_active` stays low.
- `pulse_active` rising while in SWITCH: LOAD is deferred until it falls.
- `wr_en` in the same cycle as LOAD of the same slot: LOAD uses the old contents. The new data is in the table next cycle.
- Reset mid-operation: all state clears immediately (async). Sequencing restarts from slot 0.

## Configuration
- `ASKA_SEQ_OVERLAP_CHECK_EN`
  - Defined:
    - A slot with (ele1 & ele2) ≠ 0 (an electrode driven both ways) is ineligible.
    - Attempting to select such a mask-enabled slot sets `fault`. It stays set until reset.
    - If all masked slots overlap, the block stays in or returns to IDLE.
  - Undefined: slots load verbatim and `fault` is tied 0.

## Structure
- Shared package `aska_pkg`:
  - State encoding constants (IDLE, LOAD, RUN, SWITCH).
  - `ASKA_NSLOT`, `ASKA_ELE_W` defaults.
- Sub-module `aska_rr_pick`: combinational round-robin first-set-bit finder.
  - Inputs: eligible vector, start index.
  - Outputs: index, valid.
- Instantiated in `aska_dig` between `aska_spi` outputs and `aska_npg` electrode inputs.

## Test plan
- Write slots 0..3 with distinct patterns, mask=4'b1111, pulses_per_slot=2, emit 8 pulses → `slot_idx` sequence 0,0,1,1,2,2,3,3, then 0. `slot_strobe` pulses once per load.
- mask=4'b0101, pulses_per_slot=0 → rotates 0,2,0,2 every pulse. Count-0 treated as 1.
- Hold `pulse_active` high across the switch point, then rewrite slot 1 while slot 1 is active → `ele1`/`ele2` unchanged until `pulse_active`=0. New data appears only on the next load of slot 1.
- Deassert `enable` mid-pulse → outputs held until the pulse falls, then 0 within 1 cycle. Re-enable → restarts at the lowest eligible slot.
- With the macro: slot 1 has ele1=ele2=32'h1, mask=4'b0011 → slot 1 skipped, `fault`=1 and sticky, only slot 0 is loaded. Without the macro: slot 1 loads and `fault`=0.
- Assert `resetn`=0 while in RUN at slot 2 → all outputs 0 immediately, table cleared.

Source files
------------

// File: rtl/aska_pkg.sv
// aska_pkg: shared constants and state encoding for the aska electrode sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default slot/width parameters and the sequencer state enum.
package aska_pkg;

  localparam int ASKA_NSLOT = 4;   // pattern slots (power of 2, 2..8)
  localparam int ASKA_ELE_W = 32;  // electrode vector width
  localparam int ASKA_CNT_W = 8;   // pulse counter width

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_SWITCH = 2'd3
  } seq_state_e;

endpackage

// File: rtl/aska_seq_if.sv
// aska_seq_if: pattern table write port plus the active-pattern bus toward aska_npg.
// Latency: n/a (wires only).
// Backpressure: none; writes are single-cycle strobes, pattern bus is level-valid.
// Modports: master = table writer / pattern consumer side, slave = the sequencer.
interface aska_seq_if
  import aska_pkg::*;
#(
  parameter int NSLOT = ASKA_NSLOT,
  parameter int ELE_W = ASKA_ELE_W,
  localparam int IW   = $clog2(NSLOT)
) ();

  // table write port
  logic             wr_en;
  logic [IW-1:0]    wr_addr;
  logic [ELE_W-1:0] wr_ele1;
  logic [ELE_W-1:0] wr_ele2;

  // active pattern
  logic [ELE_W-1:0] ele1;
  logic [ELE_W-1:0] ele2;
  logic [IW-1:0]    slot_idx;
  logic             slot_strobe;

  modport master (
    output wr_en, wr_addr, wr_ele1, wr_ele2,
    input  ele1, ele2, slot_idx, slot_strobe
  );

  modport slave (
    input  wr_en, wr_addr, wr_ele1, wr_ele2,
    output ele1, ele2, slot_idx, slot_strobe
  );

endinterface

// File: rtl/aska_rr_pick.sv
// aska_rr_pick: combinational round-robin finder; first set bit of elig_i at or after start_i, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: elig_i eligible vector, start_i search start, idx_o picked index, vld_o any bit set.
module aska_rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] start_i,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  logic [IW-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest hit is written last
  // and wins. N is a power of two, so IW-bit addition wraps modulo N for free.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = start_i + IW'(k);
      if (elig_i[cand]) begin
        idx_o = cand;
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aska_seq.sv
// aska_seq: electrode-pattern sequencer; rotates round-robin through enabled table slots,
//   presenting one ele1/ele2 pair to aska_npg and changing it only while pulse_active is low.
// Latency: pattern registered 1 cycle after the load decision; 2 cycles from the last counted
//   pulse falling edge to the new pattern (SWITCH, LOAD).
// Backpressure: pulse_active high stalls any pattern change (SWITCH waits, IDLE waits).
// Ports: clk, resetn (async active-low), enable, pulse_active, slot_mask, pulses_per_slot,
//   fault (sticky overlap fault), bus (aska_seq_if.slave: table write port + active pattern).
// Build option: define ASKA_SEQ_OVERLAP_CHECK_EN to reject slots with (ele1 & ele2) != 0 and
//   raise fault; undefined, slots load verbatim and fault is tied 0.
module aska_seq
  import aska_pkg::*;
#(
  parameter int NSLOT = ASKA_NSLOT,
  parameter int ELE_W = ASKA_ELE_W,
  parameter int CNT_W = ASKA_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             pulse_active,
  input  logic [NSLOT-1:0] slot_mask,
  input  logic [CNT_W-1:0] pulses_per_slot,
  output logic             fault,
  aska_seq_if.slave        bus
);

  localparam int IW = $clog2(NSLOT);

  seq_state_e state_q, state_d;

  logic [ELE_W-1:0] tbl1_q [NSLOT];
  logic [ELE_W-1:0] tbl2_q [NSLOT];

  logic [ELE_W-1:0] ele1_q, ele2_q;
  logic [IW-1:0]    idx_q;
  logic             strobe_q;
  logic             pa_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NSLOT-1:0] elig;
  logic [IW-1:0]    start_idx;
  logic [IW-1:0]    pick_idx;
  logic             pick_vld;
  logic [CNT_W-1:0] pps_eff;
  logic             fall;
  logic             last_pulse;
  logic             do_load;
  logic             do_clear;

  // ---------------------------------------------------------------------------
  // Eligibility
  // ---------------------------------------------------------------------------
`ifdef ASKA_SEQ_OVERLAP_CHECK_EN
  logic [NSLOT-1:0] ovl;
  logic             try_sel;
  logic             fault_q;

  // An electrode set in both ele1 and ele2 would be driven both ways.
  always_comb begin
    ovl = '0;
    for (int i = 0; i < NSLOT; i++) begin
      ovl[i] = |(tbl1_q[i] & tbl2_q[i]);
    end
  end

  assign elig = slot_mask & ~ovl;

  // A selection is attempted whenever IDLE or SWITCH would pick a slot.
  assign try_sel = enable && !pulse_active &&
                   ((state_q == ST_IDLE) || (state_q == ST_SWITCH));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fault_q <= 1'b0;
    end else if (try_sel && |(slot_mask & ovl)) begin
      fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`else
  assign elig  = slot_mask;
  assign fault = 1'b0;
`endif

  // From IDLE the search always starts at slot 0, otherwise just past the active slot.
  assign start_idx = (state_q == ST_IDLE) ? '0 : idx_q + 1'b1;

  aska_rr_pick #(.N(NSLOT)) u_pick (
    .elig_i  (elig),
    .start_i (start_idx),
    .idx_o   (pick_idx),
    .vld_o   (pick_vld)
  );

  // ---------------------------------------------------------------------------
  // Pulse counting
  // ---------------------------------------------------------------------------
  assign fall       = pa_prev_q & ~pulse_active;
  assign pps_eff    = (pulses_per_slot == '0) ? CNT_W'(1) : pulses_per_slot;
  // One extra bit so count+1 cannot wrap before the compare.
  assign last_pulse = ({1'b0, cnt_q} + (CNT_W + 1)'(1)) >= {1'b0, pps_eff};

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    do_load  = 1'b0;
    do_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && !pulse_active && pick_vld) begin
          do_load = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (fall && (cnt_q != '1)) begin
          cnt_d = cnt_q + 1'b1;
        end
        // Dropping enable goes straight to SWITCH, which holds the pattern
        // until the current pulse has finished.
        if (!enable || (fall && last_pulse)) begin
          state_d = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        if (!pulse_active) begin
          if (enable && pick_vld) begin
            do_load = 1'b1;
            state_d = ST_LOAD;
          end else begin
            do_clear = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The pattern is captured at the load decision edge, so it is valid during
  // the LOAD cycle together with slot_strobe. A same-cycle table write lands
  // on the same edge and therefore is not seen by this load.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pa_prev_q <= 1'b0;
      strobe_q  <= 1'b0;
      ele1_q    <= '0;
      ele2_q    <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pa_prev_q <= pulse_active;
      strobe_q  <= do_load;
      if (do_load) begin
        ele1_q <= tbl1_q[pick_idx];
        ele2_q <= tbl2_q[pick_idx];
        idx_q  <= pick_idx;
      end else if (do_clear) begin
        ele1_q <= '0;
        ele2_q <= '0;
        idx_q  <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pattern table
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NSLOT; i++) begin
        tbl1_q[i] <= '0;
        tbl2_q[i] <= '0;
      end
    end else if (bus.wr_en) begin
      tbl1_q[bus.wr_addr] <= bus.wr_ele1;
      tbl2_q[bus.wr_addr] <= bus.wr_ele2;
    end
  end

  assign bus.ele1        = ele1_q;
  assign bus.ele2        = ele2_q;
  assign bus.slot_idx    = idx_q;
  assign bus.slot_strobe = strobe_q;

endmodule

// File: tb/tb_aska_seq.sv
// tb_aska_seq: directed self-checking bench for aska_seq.
// Latency: n/a.
// Backpressure: n/a.
module tb_aska_seq;
  import aska_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic       pulse_active = 1'b0;
  logic [3:0] slot_mask = 4'b0000;
  logic [7:0] pulses_per_slot = 8'd0;
  logic       fault;

  int n_checks = 0;
  int n_err    = 0;
  int n_strobe = 0;

  aska_seq_if #(.NSLOT(4), .ELE_W(32)) bus ();

  aska_seq #(.NSLOT(4), .ELE_W(32), .CNT_W(8)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .enable          (enable),
    .pulse_active    (pulse_active),
    .slot_mask       (slot_mask),
    .pulses_per_slot (pulses_per_slot),
    .fault           (fault),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.slot_strobe) n_strobe++;
  end

`ifdef ASKA_SEQ_OVERLAP_CHECK_EN
  localparam logic [31:0] EXP_FAULT = 32'd1;
  localparam logic [31:0] EXP_OV0   = 32'd0;
  localparam logic [31:0] EXP_OV1   = 32'd0;
`else
  localparam logic [31:0] EXP_FAULT = 32'd0;
  localparam logic [31:0] EXP_OV0   = 32'd1;
  localparam logic [31:0] EXP_OV1   = 32'd0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr_slot(input int a, input logic [31:0] e1, input logic [31:0] e2);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 2'(a);
    bus.wr_ele1 = e1;
    bus.wr_ele2 = e2;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic do_pulse(input int hi, input int lo);
    pulse_active = 1'b1;
    repeat (hi) @(negedge clk);
    pulse_active = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    int exp1 [8];
    int exp2 [3];
    logic [31:0] exp5 [3];
    exp1 = '{0, 0, 1, 1, 2, 2, 3, 3};
    exp2 = '{0, 2, 0};
    exp5 = '{EXP_OV0, EXP_OV1, EXP_OV0};

    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_ele1 = '0;
    bus.wr_ele2 = '0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ele1", bus.ele1, 32'h0);
    check("rst_ele2", bus.ele2, 32'h0);
    check("rst_idx", 32'(bus.slot_idx), 32'd0);
    check("rst_strobe", 32'(bus.slot_strobe), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // test 1: four slots, 2 pulses each
    for (int i = 0; i < 4; i++) wr_slot(i, 32'h1 << i, 32'h100 << i);
    n_strobe = 0;
    slot_mask = 4'b1111;
    pulses_per_slot = 8'd2;
    enable = 1'b1;
    @(negedge clk);
    check("t1_load_strobe", 32'(bus.slot_strobe), 32'd1);
    check("t1_load_idx", 32'(bus.slot_idx), 32'd0);
    check("t1_load_ele1", bus.ele1, 32'h1);
    check("t1_load_ele2", bus.ele2, 32'h100);
    @(negedge clk);
    check("t1_strobe_1cyc", 32'(bus.slot_strobe), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_seq%0d", i), 32'(bus.slot_idx), 32'(exp1[i]));
      do_pulse(2, 3);
    end
    check("t1_wrap_idx", 32'(bus.slot_idx), 32'd0);
    check("t1_wrap_ele1", bus.ele1, 32'h1);
    check("t1_strobes", 32'(n_strobe), 32'd5);

    // test 2: mask 0101, pps=0 rotates every pulse
    slot_mask = 4'b0101;
    pulses_per_slot = 8'd0;
    pulse_active = 1'b1;
    repeat (2) @(negedge clk);
    pulse_active = 1'b0;
    @(negedge clk);
    check("t2_switch_strobe", 32'(bus.slot_strobe), 32'd0);
    check("t2_switch_idx", 32'(bus.slot_idx), 32'd0);
    @(negedge clk);
    check("t2_load_strobe", 32'(bus.slot_strobe), 32'd1);
    check("t2_load_idx", 32'(bus.slot_idx), 32'd2);
    check("t2_load_ele1", bus.ele1, 32'h4);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      do_pulse(2, 3);
      check($sformatf("t2_seq%0d", i), 32'(bus.slot_idx), 32'(exp2[i]));
    end

    // test 3: pulse held high across switch point, rewrite active slot 1
    slot_mask = 4'b1111;
    pulses_per_slot = 8'd1;
    do_pulse(2, 3);
    check("t3_at_slot1", 32'(bus.slot_idx), 32'd1);
    pulse_active = 1'b1;
    @(negedge clk);
    pulse_active = 1'b0;
    @(negedge clk);
    pulse_active = 1'b1;
    wr_slot(1, 32'h0001_0000, 32'h0002_0000);
    repeat (3) @(negedge clk);
    check("t3_hold_idx", 32'(bus.slot_idx), 32'd1);
    check("t3_hold_ele1", bus.ele1, 32'h2);
    check("t3_hold_ele2", bus.ele2, 32'h200);
    check("t3_hold_strobe", 32'(bus.slot_strobe), 32'd0);
    pulse_active = 1'b0;
    @(negedge clk);
    check("t3_release_idx", 32'(bus.slot_idx), 32'd2);
    check("t3_release_strobe", 32'(bus.slot_strobe), 32'd1);
    @(negedge clk);
    repeat (3) do_pulse(2, 3);
    check("t3_reload_idx", 32'(bus.slot_idx), 32'd1);
    check("t3_reload_ele1", bus.ele1, 32'h0001_0000);
    check("t3_reload_ele2", bus.ele2, 32'h0002_0000);

    // test 4: enable dropped mid-pulse
    pulses_per_slot = 8'd4;
    pulse_active = 1'b1;
    repeat (2) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_held_ele1", bus.ele1, 32'h0001_0000);
    check("t4_held_idx", 32'(bus.slot_idx), 32'd1);
    pulse_active = 1'b0;
    @(negedge clk);
    check("t4_zero_ele1", bus.ele1, 32'h0);
    check("t4_zero_ele2", bus.ele2, 32'h0);
    check("t4_zero_idx", 32'(bus.slot_idx), 32'd0);
    slot_mask = 4'b0110;
    enable = 1'b1;
    @(negedge clk);
    check("t4_restart_strobe", 32'(bus.slot_strobe), 32'd1);
    check("t4_restart_idx", 32'(bus.slot_idx), 32'd1);
    @(negedge clk);

    // test 5: overlapping slot 1
    enable = 1'b0;
    repeat (3) @(negedge clk);
    wr_slot(1, 32'h1, 32'h1);
    slot_mask = 4'b0011;
    pulses_per_slot = 8'd1;
    enable = 1'b1;
    @(negedge clk);
    check("t5_first_idx", 32'(bus.slot_idx), 32'd0);
    check("t5_first_strobe", 32'(bus.slot_strobe), 32'd1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      do_pulse(2, 3);
      check($sformatf("t5_seq%0d", i), 32'(bus.slot_idx), exp5[i]);
    end
    check("t5_fault", 32'(fault), EXP_FAULT);
    slot_mask = 4'b0001;
    do_pulse(2, 3);
    check("t5_mask1_idx", 32'(bus.slot_idx), 32'd0);
    check("t5_fault_sticky", 32'(fault), EXP_FAULT);

    // test 6: reset while running at slot 2
    slot_mask = 4'b0100;
    do_pulse(2, 3);
    check("t6_at_slot2", 32'(bus.slot_idx), 32'd2);
    check("t6_slot2_ele1", bus.ele1, 32'h4);
    #2 resetn = 1'b0;
    #1;
    check("t6_rst_ele1", bus.ele1, 32'h0);
    check("t6_rst_ele2", bus.ele2, 32'h0);
    check("t6_rst_idx", 32'(bus.slot_idx), 32'd0);
    check("t6_rst_strobe", 32'(bus.slot_strobe), 32'd0);
    check("t6_rst_fault", 32'(fault), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("t6_restart_strobe", 32'(bus.slot_strobe), 32'd1);
    check("t6_restart_idx", 32'(bus.slot_idx), 32'd2);
    check("t6_table_clr_ele1", bus.ele1, 32'h0);
    check("t6_table_clr_ele2", bus.ele2, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
